// File: rtl/pc_unit_if.sv
// Fetch-side bundle for the program-counter unit: redirect/call/return
// controls in, current and next PC plus return-stack status out.
interface pc_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             stall;
    logic             exception_en;
    logic             redirect_en;
    logic [WIDTH-1:0] redirect_target;
    logic             call_en;
    logic             ret_en;
    logic [WIDTH-1:0] ret_fallback;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] pc_next;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_overflow;

    modport master (
        output stall,
        output exception_en,
        output redirect_en,
        output redirect_target,
        output call_en,
        output ret_en,
        output ret_fallback,
        input  pc_out,
        input  pc_next,
        input  ras_empty,
        input  ras_full,
        input  ras_overflow
    );

    modport slave (
        input  stall,
        input  exception_en,
        input  redirect_en,
        input  redirect_target,
        input  call_en,
        input  ret_en,
        input  ret_fallback,
        output pc_out,
        output pc_next,
        output ras_empty,
        output ras_full,
        output ras_overflow
    );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: registered PC, prioritised next-PC select and a
// small circular return-address stack for call/return prediction.
module pc_unit #(
    parameter int unsigned      WIDTH        = 32,
    parameter int unsigned      STEP         = 1,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0100),
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input logic      clk,
    input logic      reset,
    pc_unit_if.slave bus
);
    localparam int unsigned      PW      = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned      OW      = $clog2(RAS_DEPTH + 1);
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
    localparam logic [OW-1:0]    OCC_MAX = OW'(RAS_DEPTH);
    localparam logic [OW-1:0]    OCC_ONE = OW'(1);
    localparam logic [PW-1:0]    PTR_ONE = PW'(1);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [PW-1:0]    top_q;
    logic [PW-1:0]    top_d;
    logic [OW-1:0]    occ_q;
    logic [OW-1:0]    occ_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    logic             do_exc;
    logic             do_hold;
    logic             do_call;
    logic             do_ret;
    logic             do_redir;
    logic             ras_hit;
    logic             push_en;
    logic [PW-1:0]    push_ptr;
    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] ret_pc;

    assign seq_pc   = pc_q + STEP_W;
    assign push_ptr = top_q + PTR_ONE;
    assign ras_hit  = (occ_q != '0);
    assign ret_pc   = ras_hit ? ras_q[top_q] : bus.ret_fallback;

    // Resolve the competing controls into exactly one action per cycle.
    always_comb begin
        do_exc   = 1'b0;
        do_hold  = 1'b0;
        do_call  = 1'b0;
        do_ret   = 1'b0;
        do_redir = 1'b0;
        if (bus.exception_en) begin
            do_exc = 1'b1;
        end else if (bus.stall) begin
            do_hold = 1'b1;
        end else if (bus.call_en) begin
            do_call = 1'b1;
        end else if (bus.ret_en) begin
            do_ret = 1'b1;
        end else if (bus.redirect_en) begin
            do_redir = 1'b1;
        end
    end

    // Select the next PC; falls through to the sequential fetch address.
    always_comb begin
        pc_d = seq_pc;
        unique case (1'b1)
            do_exc:   pc_d = EXC_VECTOR;
            do_hold:  pc_d = pc_q;
            do_call:  pc_d = bus.redirect_target;
            do_ret:   pc_d = ret_pc;
            do_redir: pc_d = bus.redirect_target;
            default:  pc_d = seq_pc;
        endcase
    end

    // Return-stack bookkeeping: push on call, pop on a return that hits.
    always_comb begin
        top_d   = top_q;
        occ_d   = occ_q;
        ovf_d   = ovf_q;
        push_en = 1'b0;
        if (do_call) begin
            push_en = 1'b1;
            top_d   = push_ptr;
            if (occ_q == OCC_MAX) begin
                ovf_d = 1'b1;
            end else begin
                occ_d = occ_q + OCC_ONE;
            end
        end else if (do_ret && ras_hit) begin
            top_d = top_q - PTR_ONE;
            occ_d = occ_q - OCC_ONE;
        end
    end

    // PC and stack control state, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_VECTOR;
            top_q <= '0;
            occ_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            top_q <= top_d;
            occ_q <= occ_d;
            ovf_q <= ovf_d;
        end
    end

    // Stack storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_en) begin
            ras_q[push_ptr] <= seq_pc;
        end
    end

    assign bus.pc_out       = pc_q;
    assign bus.pc_next      = pc_d;
    assign bus.ras_empty    = (occ_q == '0);
    assign bus.ras_full     = (occ_q == OCC_MAX);
    assign bus.ras_overflow = ovf_q;
endmodule
